// File: rtl/s_term_sram_if.sv
// South-terminal SRAM bridge: frame-configured 4-phase fabric request to an SRAM macro.
// Define S_TERM_SRAM_PARITY_EN to add an even-parity bit on SRAM_D/SRAM_Q.
module s_term_sram_if #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_LATENCY    = 1,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int CFG_FRAME       = 0,
`ifdef S_TERM_SRAM_PARITY_EN
  localparam int SramW = DATA_WIDTH + 1
`else
  localparam int SramW = DATA_WIDTH
`endif
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  output logic                       UserCLKo,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  input  logic                       FAB_REQ,
  input  logic                       FAB_WE,
  input  logic [ADDR_WIDTH-1:0]      FAB_ADDR,
  input  logic [DATA_WIDTH-1:0]      FAB_WDATA,
  output logic                       FAB_ACK,
  output logic                       FAB_ERR,
  output logic [DATA_WIDTH-1:0]      FAB_RDATA,
  output logic                       FAB_BUSY,
  output logic                       SRAM_CEN,
  output logic                       SRAM_WEN,
  output logic [ADDR_WIDTH-1:0]      SRAM_A,
  output logic [SramW-1:0]           SRAM_D,
  input  logic [SramW-1:0]           SRAM_Q
);

  // state  | meaning
  // IDLE   | waiting for an enabled request
  // ACCESS | SRAM strobed (unless write-protected)
  // WAIT   | counting down SRAM read latency
  // RESP   | one-cycle FAB_ACK
  // DONE   | waiting for FAB_REQ to drop
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, DONE} stateT;

  localparam logic [1:0] CntInit = 2'(READ_LATENCY - 1);

  stateT                 state, nextState;
  logic [1:0]            cfg;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic [DATA_WIDTH-1:0] rdataQ;
  logic                  weQ;
  logic                  errQ;
  logic [1:0]            cnt;
  logic                  en, wp, wpBlock;

  assign UserCLKo      = UserCLK;
  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;

  // Transparent while the config frame strobe is high.
  always_latch begin
    if (Reset)
      cfg <= 2'b00;
    else if (FrameStrobe[CFG_FRAME])
      cfg <= FrameData[1:0];
  end

  assign en      = cfg[0];
  assign wp      = cfg[1];
  assign wpBlock = weQ & wp;

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      addrQ  <= '0;
      wdataQ <= '0;
      weQ    <= 1'b0;
      errQ   <= 1'b0;
      cnt    <= '0;
      rdataQ <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (FAB_REQ && en) begin
            addrQ  <= FAB_ADDR;
            wdataQ <= FAB_WDATA;
            weQ    <= FAB_WE;
          end
        end
        ACCESS: begin
          if (wpBlock) errQ <= 1'b1;
          cnt <= CntInit;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            rdataQ <= SRAM_Q[DATA_WIDTH-1:0];
`ifdef S_TERM_SRAM_PARITY_EN
            if (SRAM_Q[DATA_WIDTH] != ^SRAM_Q[DATA_WIDTH-1:0]) errQ <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE: begin
          if (!FAB_REQ) errQ <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (FAB_REQ && en) nextState = ACCESS;
      ACCESS:  nextState = weQ ? RESP : WAIT;
      WAIT:    if (cnt == 2'd0) nextState = RESP;
      RESP:    nextState = DONE;
      DONE:    if (!FAB_REQ) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign FAB_ACK   = (state == RESP);
  assign FAB_ERR   = (state == RESP) & errQ;
  assign FAB_BUSY  = (state != IDLE);
  assign FAB_RDATA = rdataQ;

  // Request registers drive the macro directly, so address/data hold between accesses.
  assign SRAM_CEN = ~((state == ACCESS) & ~wpBlock);
  assign SRAM_WEN = SRAM_CEN | ~weQ;
  assign SRAM_A   = addrQ;
`ifdef S_TERM_SRAM_PARITY_EN
  assign SRAM_D   = {^wdataQ, wdataQ};
`else
  assign SRAM_D   = wdataQ;
`endif

endmodule

// File: doc/s_term_sram_if.md
Name: s_term_sram_if

Overview:
Parametrised south-terminal tile that bridges fabric user logic to an external SRAM macro through a registered, 4-phase request/acknowledge interface with configurable read latency.
- Configuration comes from a frame-latched control word: enable and write-protect.
- The tile re-buffers the configuration chain (FrameData, FrameStrobe) and UserCLK toward the column above.
- It sits at the bottom of an SRAM-attached fabric column.

Parameters:
ADDR_WIDTH, 10, SRAM word-address width
DATA_WIDTH, 32, SRAM/fabric data width
READ_LATENCY, 1, SRAM clock-to-Q cycles (1..4)
MaxFramesPerCol, 20, FrameStrobe width
FrameBitsPerRow, 32, FrameData width
CFG_FRAME, 0, FrameStrobe index that loads the control word

Ports:
UserCLK  in  1  fabric user clock; all flops rising-edge
Reset  in  1  asynchronous, active-high reset
UserCLKo  out  1  buffered UserCLK to the tile above
FrameData  in  FrameBitsPerRow  config data
FrameData_O  out  FrameBitsPerRow  buffered FrameData
FrameStrobe  in  MaxFramesPerCol  config strobes
FrameStrobe_O  out  MaxFramesPerCol  buffered FrameStrobe
FAB_REQ  in  1  fabric request, held high until FAB_ACK is seen
FAB_WE  in  1  1 = write, 0 = read
FAB_ADDR  in  ADDR_WIDTH  word address
FAB_WDATA  in  DATA_WIDTH  write data
FAB_ACK  out  1  one-cycle completion pulse
FAB_ERR  out  1  error qualifier, valid with FAB_ACK
FAB_RDATA  out  DATA_WIDTH  registered read data
FAB_BUSY  out  1  high in any state other than IDLE
SRAM_CEN  out  1  chip enable, active low
SRAM_WEN  out  1  write enable, active low
SRAM_A  out  ADDR_WIDTH  SRAM address
SRAM_D  out  DATA_WIDTH(+1)  SRAM write data
SRAM_Q  in  DATA_WIDTH(+1)  SRAM read data

Behaviour:
- Configuration and pass-through:
  - UserCLKo, FrameData_O and FrameStrobe_O are pure buffered pass-through; there is no added latency.
  - cfg[1:0] is a transparent latch, open while FrameStrobe[CFG_FRAME]=1, capturing FrameData[1:0].
  - cfg[0] = EN, cfg[1] = WP (write-protect). Reset clears cfg to 0.
- Reset values: FSM=IDLE, FAB_ACK=0, FAB_ERR=0, FAB_RDATA=0, FAB_BUSY=0, SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0. Reset mid-transaction aborts immediately to these values.
- FSM states: IDLE, ACCESS, WAIT, RESP, DONE.
- IDLE:
  - If FAB_REQ=1 and EN=1: capture FAB_ADDR, FAB_WDATA and FAB_WE into req registers, then go to ACCESS.
  - If FAB_REQ=1 and EN=0: stay in IDLE; no ACK is ever issued.
- ACCESS (exactly 1 cycle):
  - Write with WP=1: SRAM_CEN stays 1, err_q is set, go to RESP.
  - Otherwise: SRAM_CEN=0, SRAM_WEN=~we_q, SRAM_A=addr_q, SRAM_D=wdata_q.
  - Write goes to RESP. Read goes to WAIT with cnt=READ_LATENCY-1.
- WAIT:
  - SRAM_CEN=1. cnt decrements each cycle.
  - On the cycle cnt==0, SRAM_Q is registered into FAB_RDATA and the FSM goes to RESP.
- RESP (1 cycle): FAB_ACK=1, FAB_ERR=err_q, then go to DONE.
- DONE: wait for FAB_REQ=0, then clear err_q and go to IDLE. A request still high is not re-accepted.
- Latency, counting the IDLE accept edge as 0:
  - Write: SRAM_CEN low in cycle 1, FAB_ACK in cycle 2.
  - Read: FAB_ACK in cycle 2+READ_LATENCY.
- FAB_RDATA holds its value until the next successful read capture. Writes and errored accesses do not change it.
- EN cleared mid-transaction: the transaction completes normally. EN only gates acceptance in IDLE.
- Config change to WP after ACCESS has no effect on the in-flight access.
- SRAM_A/SRAM_D hold their last values when SRAM_CEN=1.

Optional Feature:
S_TERM_SRAM_PARITY_EN:
- Defined:
  - SRAM_D/SRAM_Q are DATA_WIDTH+1 bits wide; the MSB is even parity over the data bits.
  - Writes store ^wdata.
  - A read whose parity mismatches still captures the data bits and returns FAB_ACK with FAB_ERR=1.
- Undefined:
  - SRAM_D/SRAM_Q are DATA_WIDTH bits wide.
  - FAB_ERR is set only by a write-protect violation.

Test Plan:
- Reset asserted asynchronously mid-WAIT -> next cycle SRAM_CEN=1, FAB_BUSY=0, FAB_RDATA=0, cfg=0, FSM IDLE.
- Frame strobe loads cfg=01. Then write addr 0x005, data 0xDEADBEEF -> SRAM_CEN=0/SRAM_WEN=0/SRAM_A=0x005 in cycle 1, FAB_ACK=1 and FAB_ERR=0 in cycle 2.
- READ_LATENCY=3, read addr 0x005, SRAM model returns 0xDEADBEEF -> FAB_ACK in cycle 5, FAB_RDATA=0xDEADBEEF held afterwards.
- cfg=11, write -> SRAM_CEN never low, FAB_ACK=1 with FAB_ERR=1, FAB_RDATA unchanged.
- cfg=00 with FAB_REQ held high for 10 cycles -> no ACK, FAB_BUSY=0. Then FAB_REQ held high after ACK -> no second access until FAB_REQ drops.
- PARITY_EN: model flips the parity bit on a read of 0x0000_0001 -> FAB_ACK with FAB_ERR=1, FAB_RDATA=0x00000001.
